// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: gathers two 16-bit operands from a byte stream, adds them
// one nibble per cycle on a shared 4-bit slice, and returns the sum low byte,
// high byte and carry byte over a valid/ready byte interface.
module adder_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [15:0] sum_o,
  output logic        cout_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {LOAD, ADD, SEND} state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q;
  logic [1:0]      add_cnt_q;
  logic [1:0]      send_idx_q;
  logic [IW-1:0]   idle_cnt_q;
  logic [15:0]     a_q, b_q;
  logic [11:0]     acc_q;
  logic [15:0]     sum_q;
  logic            carry_q, cout_q, overrun_q;

  logic            rx_take, timeout_hit, last_byte, tx_fire, carry_in;
  logic [1:0]      cap_idx;
  logic [4:0]      slice;

  // Frame bookkeeping and the shared nibble adder
  always_comb begin
    rx_take     = (state_q == LOAD) && rx_valid_i;
    timeout_hit = (state_q == LOAD) && (byte_cnt_q != 2'd0) && (idle_cnt_q == IDLE_MAX);
    // A byte arriving in the timeout cycle starts a fresh frame
    cap_idx     = timeout_hit ? 2'd0 : byte_cnt_q;
    last_byte   = rx_take && (cap_idx == 2'd3);
    tx_fire     = (state_q == SEND) && tx_ready_i;
    carry_in    = (add_cnt_q == 2'd0) ? 1'b0 : carry_q;
    slice       = {1'b0, a_q[{add_cnt_q, 2'b00} +: 4]}
                + {1'b0, b_q[{add_cnt_q, 2'b00} +: 4]}
                + {4'b0, carry_in};
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LOAD;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (last_byte) state_d = ADD;
      ADD:     if (add_cnt_q == 2'd3) state_d = SEND;
      SEND:    if (tx_fire && (send_idx_q == 2'd2)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Output decode from state and result registers
  always_comb begin
    busy_o     = (state_q == ADD) || (state_q == SEND);
    tx_valid_o = (state_q == SEND);
    timeout_o  = timeout_hit;
    tx_data_o  = '0;
    if (state_q == SEND) begin
      unique case (send_idx_q)
        2'd0:    tx_data_o = sum_q[7:0];
        2'd1:    tx_data_o = sum_q[15:8];
        2'd2:    tx_data_o = {7'b0, cout_q};
        default: tx_data_o = '0;
      endcase
    end
  end

  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign overrun_o = overrun_q;

  // Operand capture, byte counter and inter-byte idle timer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q        <= '0;
      b_q        <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      if (rx_take) begin
        unique case (cap_idx)
          2'd0: a_q[7:0]  <= rx_data_i;
          2'd1: a_q[15:8] <= rx_data_i;
          2'd2: b_q[7:0]  <= rx_data_i;
          2'd3: b_q[15:8] <= rx_data_i;
          default: ;
        endcase
        byte_cnt_q <= cap_idx + 2'd1;
      end else if (timeout_hit) begin
        byte_cnt_q <= '0;
      end
      if ((state_q == LOAD) && (byte_cnt_q != 2'd0) && !timeout_hit && !rx_valid_i)
        idle_cnt_q <= idle_cnt_q + 1'b1;
      else
        idle_cnt_q <= '0;
    end
  end

  // Nibble-serial addition; the result registers load only on the last nibble
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_cnt_q <= '0;
      carry_q   <= 1'b0;
      acc_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else if (state_q == ADD) begin
      add_cnt_q <= add_cnt_q + 2'd1;
      carry_q   <= slice[4];
      unique case (add_cnt_q)
        2'd0: acc_q[3:0]  <= slice[3:0];
        2'd1: acc_q[7:4]  <= slice[3:0];
        2'd2: acc_q[11:8] <= slice[3:0];
        2'd3: begin
          sum_q  <= {slice[3:0], acc_q};
          cout_q <= slice[4];
        end
        default: ;
      endcase
    end else begin
      add_cnt_q <= '0;
      carry_q   <= 1'b0;
    end
  end

  // Result byte index and overrun flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      send_idx_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (state_q != SEND)
        send_idx_q <= '0;
      else if (tx_fire)
        send_idx_q <= (send_idx_q == 2'd2) ? 2'd0 : send_idx_q + 2'd1;
      overrun_q <= rx_valid_i && (state_q != LOAD);
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: frames are driven byte by byte, expected result
// bytes go into a scoreboard queue and are compared as the DUT transfers them.
module tb_adder_seq_ctrl;

  logic        clk;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [15:0] sum_o;
  logic        cout_o;
  logic        busy_o;
  logic        timeout_o;
  logic        overrun_o;

  adder_seq_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .sum_o     (sum_o),
    .cout_o    (cout_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o),
    .overrun_o (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [15:0] exp_sum;
  logic        exp_cout;
  int first_lat, unstable, ovr_cnt;
  logic busy_after, txv_after;

  // Pushes the expected result bytes and drives the four operand bytes
  task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [31:0] bytes;
    s = {1'b0, a} + {1'b0, b};
    exp_sum  = s[15:0];
    exp_cout = s[16];
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back({7'b0, s[16]});
    bytes = {b, a};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data_i  = bytes[8*i +: 8];
      rx_valid_i = 1'b1;
    end
  endtask

  // Steps the clock, drives tx_ready with the given stall, records transfers
  task automatic collect(input int want, input int stall, input int inject);
    int got, cyc, st;
    logic [7:0] held;
    bit holding;
    got = 0; cyc = 0; st = 0; holding = 0; held = '0;
    first_lat = -1; unstable = 0; ovr_cnt = 0;
    while (got < want && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rx_valid_i = (cyc == inject);
      rx_data_i  = 8'hA5;
      if (overrun_o) ovr_cnt++;
      if (tx_valid_o && first_lat < 0) first_lat = cyc;
      if (holding && tx_data_o !== held) unstable++;
      if (tx_valid_o) begin
        tx_ready_i = (st >= stall);
        if (tx_ready_i) begin
          obs_q.push_back(tx_data_o);
          got++; st = 0; holding = 0;
        end else begin
          st++; holding = 1; held = tx_data_o;
        end
      end else begin
        tx_ready_i = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    if (overrun_o) ovr_cnt++;
    busy_after = busy_o;
    txv_after  = tx_valid_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_o); end
    vectors++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data_o); end
    vectors++; if (sum_o !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum_o); end
    vectors++; if (cout_o !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout_o); end
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vectors++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    vectors++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] e, o;
    exp_q.delete(); obs_q.delete();
    send_frame(16'h1234, 16'h0FCD);
    collect(3, 0, 0);
    vectors++; if (first_lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", first_lat); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++; if (o !== e) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, o, e); end
    end
    vectors++; if (sum_o !== 16'h2201) begin errors++; $display("FAIL basic_sum: got %h want 2201", sum_o); end
    vectors++; if (cout_o !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", cout_o); end
    vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
    vectors++; if (txv_after !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b want 0", txv_after); end
  endtask

  task automatic test_carry();
    logic [7:0] e, o;
    exp_q.delete(); obs_q.delete();
    send_frame(16'hFFFF, 16'h0001);
    collect(3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++; if (o !== e) begin errors++; $display("FAIL carry_byte%0d: got %h want %h", i, o, e); end
    end
    vectors++; if (sum_o !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h want 0000", sum_o); end
    vectors++; if (cout_o !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b want 1", cout_o); end
  endtask

  task automatic test_stall();
    logic [7:0] e, o;
    exp_q.delete(); obs_q.delete();
    send_frame(16'h1234, 16'h0FCD);
    collect(3, 5, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++; if (o !== e) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, o, e); end
    end
    vectors++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
    vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL stall_busy_after: got %b want 0", busy_after); end
    vectors++; if (txv_after !== 1'b0) begin errors++; $display("FAIL stall_extra_byte: got valid %b want 0", txv_after); end
  endtask

  task automatic test_timeout();
    logic [7:0] e, o;
    int pulses, c;
    bit seen;
    logic [31:0] bytes;
    // Two bytes then silence: exactly one timeout pulse
    @(negedge clk); rx_data_i = 8'h11; rx_valid_i = 1'b1;
    @(negedge clk); rx_data_i = 8'h22; rx_valid_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); rx_valid_i = 1'b0;
      if (timeout_o) pulses++;
    end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
    exp_q.delete(); obs_q.delete();
    send_frame(16'h1357, 16'h2468);
    collect(3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++; if (o !== e) begin errors++; $display("FAIL timeout_next_byte%0d: got %h want %h", i, o, e); end
    end
    // A byte in the timeout cycle itself begins a new frame
    exp_q.delete(); obs_q.delete();
    @(negedge clk); rx_data_i = 8'h99; rx_valid_i = 1'b1;
    seen = 0; c = 0;
    while (!seen && c < 30) begin
      @(negedge clk); c++;
      rx_valid_i = 1'b0;
      if (timeout_o) seen = 1;
    end
    vectors++; if (seen !== 1'b1) begin errors++; $display("FAIL timeout_coincide_seen: got %b want 1", seen); end
    if (seen) begin
      exp_sum = 16'hABCD + 16'h1111;
      exp_q.push_back(exp_sum[7:0]); exp_q.push_back(exp_sum[15:8]); exp_q.push_back(8'h00);
      bytes = {16'h1111, 16'hABCD};
      rx_data_i = bytes[7:0]; rx_valid_i = 1'b1;
      for (int i = 1; i < 4; i++) begin
        @(negedge clk); rx_data_i = bytes[8*i +: 8]; rx_valid_i = 1'b1;
      end
      collect(3, 0, 0);
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
        vectors++; if (o !== e) begin errors++; $display("FAIL timeout_coincide_byte%0d: got %h want %h", i, o, e); end
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e, o;
    int inj[2];
    inj[0] = 2; inj[1] = 6;
    for (int f = 0; f < 2; f++) begin
      exp_q.delete(); obs_q.delete();
      send_frame(16'h4321 + 16'(f), 16'h1F0F);
      collect(3, 0, inj[f]);
      vectors++; if (ovr_cnt !== 1) begin errors++; $display("FAIL overrun_pulse%0d: got %0d want 1", f, ovr_cnt); end
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
        vectors++; if (o !== e) begin errors++; $display("FAIL overrun%0d_byte%0d: got %h want %h", f, i, o, e); end
      end
      vectors++; if (sum_o !== exp_sum) begin errors++; $display("FAIL overrun%0d_sum: got %h want %h", f, sum_o, exp_sum); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] e, o;
    int c, extra;
    bit sent;
    exp_q.delete(); obs_q.delete();
    send_frame(16'h1234, 16'h0FCD);
    sent = 0; c = 0;
    while (!sent && c < 50) begin
      @(negedge clk); c++;
      rx_valid_i = 1'b0;
      if (tx_valid_o) begin
        tx_ready_i = 1'b1; sent = 1;
        vectors++; if (tx_data_o !== 8'h01) begin errors++; $display("FAIL rstsend_first: got %h want 01", tx_data_o); end
      end
    end
    vectors++; if (sent !== 1'b1) begin errors++; $display("FAIL rstsend_no_valid: got %b want 1", sent); end
    @(negedge clk);
    tx_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    vectors++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL rstsend_valid: got %b want 0", tx_valid_o); end
    vectors++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL rstsend_data: got %h want 00", tx_data_o); end
    vectors++; if ({sum_o, cout_o, busy_o} !== 18'h0) begin errors++; $display("FAIL rstsend_regs: got %h want 0", {sum_o, cout_o, busy_o}); end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1; tx_ready_i = 1'b1;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tx_valid_o) extra++;
    end
    tx_ready_i = 1'b0;
    vectors++; if (extra !== 0) begin errors++; $display("FAIL rstsend_extra: got %0d valid cycles want 0", extra); end
    exp_q.delete(); obs_q.delete();
    send_frame(16'hFFFF, 16'h0001);
    collect(3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++; if (o !== e) begin errors++; $display("FAIL rstsend_after_byte%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    logic [15:0] a, b;
    for (int f = 0; f < 5; f++) begin
      exp_q.delete(); obs_q.delete();
      a = 16'($urandom);
      b = 16'($urandom);
      send_frame(a, b);
      collect(3, f % 3, 0);
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
        vectors++; if (o !== e) begin errors++; $display("FAIL b2b%0d_byte%0d: got %h want %h", f, i, o, e); end
      end
      vectors++; if ({cout_o, sum_o} !== {exp_cout, exp_sum}) begin
        errors++; $display("FAIL b2b%0d_sum: got %h want %h", f, {cout_o, sum_o}, {exp_cout, exp_sum});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_stall();
    test_timeout();
    test_overrun();
    test_reset_mid_send();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
